booth_mult_arbiter: RTL and testbench
=====================================

# booth_mult_arbiter

Round-robin scheduler that shares one sequential Booth multiplier between NREQ requesters. It accepts one operand pair at a time, drives the multiplier's start/operand interface and waits for its finish strobe. It then returns the signed 2N-bit product to the originating requester. A watchdog aborts any transaction whose multiplier never finishes and flags an error.

## Interface
- NREQ, 4, number of requesters (2..16)
- N, 8, operand width in bits; product is 2N bits, two's complement
- TIMEOUT, 32, maximum cycles spent in WAIT before abort (must exceed the multiplier latency)
- i_clk  input  1  clock; all logic on rising edge
- i_rst_n  input  1  reset, synchronous, active-low
- i_req  input  NREQ  per-requester request level; held until granted
- i_a  input  NREQ*N  multiplier operands, requester k at [k*N +: N]
- i_b  input  NREQ*N  multiplicand operands, same packing
- o_gnt  output  NREQ  one-hot, one-cycle grant pulse
- o_rsp_valid  output  NREQ  one-hot, one-cycle response strobe
- o_rsp_data  output  2N  product, valid when any o_rsp_valid bit is set, else 0
- o_rsp_err  output  1  timeout flag, qualified by o_rsp_valid
- o_busy  output  1  high in every state except IDLE
- o_mul_start  output  1  one-cycle start pulse to multiplier
- o_mul_multiplier, o_mul_multiplicand  output  N each  operands to multiplier
- i_mul_finish  input  1  multiplier done strobe
- i_mul_result  input  2N  multiplier product, sampled with i_mul_finish

## Operation
- FSM states: IDLE, START, WAIT, RESP. Encoding is free; illegal encodings go to IDLE.
- IDLE, i_req != 0:
  - Select the first set bit at or after priority pointer ptr, searching upward with wrap.
  - Latch id, i_a[id] and i_b[id] into operand registers.
  - Go to START.
- IDLE, i_req == 0: stay in IDLE.
- START:
  - o_gnt[id]=1 and o_mul_start=1 for this one cycle.
  - Clear watchdog counter; go to WAIT.
- WAIT: counter increments each cycle.
  - i_mul_finish=1: capture i_mul_result, err=0, go to RESP.
  - Else if counter == TIMEOUT-1: result=0, err=1, go to RESP.
  - Finish and timeout in the same cycle: finish wins, err=0.
- RESP:
  - o_rsp_valid[id]=1, o_rsp_data=result, o_rsp_err=err for one cycle.
  - ptr <= (id+1) mod NREQ; go to IDLE.
- o_mul_multiplier/o_mul_multiplicand are stable from START through the cycle leaving WAIT.
- i_mul_finish outside WAIT is ignored.
- Requesters must drop i_req on the cycle after o_gnt. A request still high in IDLE is a new request.
- No response backpressure: the requester must accept o_rsp_valid when it fires.
- ptr advances only on RESP, so every active requester is served within NREQ transactions.

## Timing
- Reset: state IDLE, ptr=0, counter=0, id=0, all outputs 0.
- Reset asserted mid-transaction abandons it: no response, no grant is replayed. The multiplier shares i_rst_n.
- Request sampled in IDLE at edge t:
  - o_gnt and o_mul_start high in cycle t+1.
  - WAIT from t+2.
- Finish seen in WAIT at cycle w: response in cycle w+1, IDLE at w+2.
- Minimum spacing between grants: 3 cycles plus multiplier latency.
- All outputs are registered or decoded from the state and registers only; there is no combinational path from any input to any output.

## Test plan
- Single request, requester 0: a=3, b=5; multiplier model finishes after 9 cycles. Required: o_gnt=0001, one start pulse, o_rsp_valid=0001, o_rsp_data=16'h000F, err=0.
- Signed operands, requester 2: a=8'hFD (-3), b=5. Required: o_rsp_data=16'hFFF1 on o_rsp_valid=0100.
- All four requests raised together at reset exit. Required: grant order 0,1,2,3; each response carries its own product; no overlapping starts.
- Requesters 0 and 2 re-request immediately after each response. Required: grants alternate 0,2,0,2 for 8 transactions.
- Multiplier model never finishes. Required: o_rsp_valid fires exactly TIMEOUT+1 cycles after START, with err=1 and data=0; next request proceeds normally.
- i_rst_n pulsed low during WAIT. Required: all outputs 0 the next cycle, no o_rsp_valid for the aborted job, ptr=0.

Source files
------------

// File: rtl/booth_mult_arbiter.sv
// ---------------------------------------------------------------------------
// booth_mult_arbiter
//
// Round-robin front end that shares one sequential Booth multiplier between
// NREQ requesters. One operand pair is accepted at a time. It is handed to
// the multiplier with a start pulse, and the signed 2N-bit product is
// returned to the requester that supplied it. A watchdog gives up on a
// multiplier that never finishes and returns a zero product with an error
// flag instead.
//
// Parameters
//   NREQ    number of requesters (2..16)
//   N       operand width; products are 2N-bit two's complement
//   TIMEOUT cycles allowed in WAIT before the job is aborted
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), synchronous active-low reset
//   i_req                 per-requester request level, held until granted
//   i_a, i_b              packed operands, requester k at [k*N +: N]
//   o_gnt                 one-hot grant pulse (the START cycle)
//   o_rsp_valid           one-hot response strobe (the RESP cycle)
//   o_rsp_data            product during the response strobe, else 0
//   o_rsp_err             timeout flag, qualified by o_rsp_valid
//   o_busy                high whenever the FSM is not idle
//   o_mul_start           start pulse to the multiplier
//   o_mul_multiplier      operand A to the multiplier
//   o_mul_multiplicand    operand B to the multiplier
//   i_mul_finish          multiplier done strobe
//   i_mul_result          multiplier product, valid with i_mul_finish
// ---------------------------------------------------------------------------
module booth_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int N       = 8,
  parameter int TIMEOUT = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NREQ-1:0]     i_req,
  input  logic [NREQ*N-1:0]   i_a,
  input  logic [NREQ*N-1:0]   i_b,
  output logic [NREQ-1:0]     o_gnt,
  output logic [NREQ-1:0]     o_rsp_valid,
  output logic [2*N-1:0]      o_rsp_data,
  output logic                o_rsp_err,
  output logic                o_busy,
  output logic                o_mul_start,
  output logic [N-1:0]        o_mul_multiplier,
  output logic [N-1:0]        o_mul_multiplicand,
  input  logic                i_mul_finish,
  input  logic [2*N-1:0]      i_mul_result
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  localparam logic [IW-1:0] LAST_ID  = IW'(NREQ - 1);
  localparam logic [IW:0]   NREQ_EXT = (IW + 1)'(NREQ);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   id;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;
  logic [CW-1:0]   cnt;
  logic [2*N-1:0]  result;
  logic            err;

  logic [IW-1:0]   sel_id;
  logic            sel_found;
  logic [IW:0]     cand_sum;
  logic [IW-1:0]   cand;
  logic [NREQ-1:0] id_onehot;
  logic            wait_done;

  // Round-robin pick: walk upward from the priority pointer, wrapping at
  // NREQ, and keep the first requester found. The sum is one bit wider than
  // an index so the wrap can be detected for non-power-of-two NREQ.
  always_comb begin
    sel_id    = '0;
    sel_found = 1'b0;
    cand_sum  = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_sum = {1'b0, ptr} + (IW + 1)'(i);
      if (cand_sum >= NREQ_EXT) begin
        cand_sum = cand_sum - NREQ_EXT;
      end
      cand = cand_sum[IW-1:0];
      if (!sel_found && i_req[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  assign id_onehot = NREQ'(1) << id;

  // A job leaves WAIT either on the finish strobe or when the watchdog has
  // counted TIMEOUT cycles there; the finish strobe has priority.
  assign wait_done = i_mul_finish || (cnt == CNT_LAST);

  // State register. Reset abandons any job in flight without a response.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode. Every output comes from the state and
  // registers only, so no input reaches an output in the same cycle.
  always_comb begin
    state_nxt   = state;
    o_gnt       = '0;
    o_rsp_valid = '0;
    o_rsp_data  = '0;
    o_rsp_err   = 1'b0;
    o_mul_start = 1'b0;
    o_busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (sel_found) begin
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        o_gnt       = id_onehot;
        o_mul_start = 1'b1;
        state_nxt   = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_done) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        o_rsp_valid = id_onehot;
        o_rsp_data  = result;
        o_rsp_err   = err;
        state_nxt   = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Transaction datapath. Operands are captured only when a request is
  // accepted in IDLE, which keeps them stable to the multiplier from START
  // until the job leaves WAIT. The pointer moves past the served requester
  // only once its response has been delivered.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr    <= '0;
      id     <= '0;
      op_a   <= '0;
      op_b   <= '0;
      cnt    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            id   <= sel_id;
            op_a <= i_a[sel_id*N +: N];
            op_b <= i_b[sel_id*N +: N];
          end
        end
        ST_START: begin
          cnt <= '0;
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (i_mul_finish) begin
            result <= i_mul_result;
            err    <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            result <= '0;
            err    <= 1'b1;
          end
        end
        ST_RESP: begin
          ptr <= (id == LAST_ID) ? '0 : id + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_mul_multiplier   = op_a;
  assign o_mul_multiplicand = op_b;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// ---------------------------------------------------------------------------
// tb_booth_mult_arbiter
//
// Self-checking bench for booth_mult_arbiter. A behavioural multiplier with
// programmable latency (or none at all, to force the watchdog) answers the
// DUT's start pulses. Requesters drop their request on the cycle after
// their grant. Directed vectors cover the listed scenarios. A randomized
// phase compares grant order and products against a round-robin reference
// kept as a plain pending-request array.
// ---------------------------------------------------------------------------
module tb_booth_mult_arbiter;

  localparam int NREQ    = 4;
  localparam int N       = 8;
  localparam int TIMEOUT = 32;
  localparam int LAT     = 9;

  logic                i_clk;
  logic                i_rst_n;
  logic [NREQ-1:0]     i_req;
  logic [NREQ*N-1:0]   i_a;
  logic [NREQ*N-1:0]   i_b;
  logic [NREQ-1:0]     o_gnt;
  logic [NREQ-1:0]     o_rsp_valid;
  logic [2*N-1:0]      o_rsp_data;
  logic                o_rsp_err;
  logic                o_busy;
  logic                o_mul_start;
  logic [N-1:0]        o_mul_multiplier;
  logic [N-1:0]        o_mul_multiplicand;
  logic                i_mul_finish;
  logic [2*N-1:0]      i_mul_result;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int start_total  = 0;
  int rsp_total    = 0;

  int             mul_lat  = LAT;
  bit             mul_hang = 1'b0;
  int             mul_cnt  = 0;
  logic [2*N-1:0] mul_prod = '0;

  typedef struct {
    int             id;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] prod;
  } vec_t;

  vec_t vecs[6];

  booth_mult_arbiter #(
    .NREQ    (NREQ),
    .N       (N),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_req              (i_req),
    .i_a                (i_a),
    .i_b                (i_b),
    .o_gnt              (o_gnt),
    .o_rsp_valid        (o_rsp_valid),
    .o_rsp_data         (o_rsp_data),
    .o_rsp_err          (o_rsp_err),
    .o_busy             (o_busy),
    .o_mul_start        (o_mul_start),
    .o_mul_multiplier   (o_mul_multiplier),
    .o_mul_multiplicand (o_mul_multiplicand),
    .i_mul_finish       (i_mul_finish),
    .i_mul_result       (i_mul_result)
  );

  // Free-running clock and a cycle counter that advances on each rising edge.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    forever begin
      @(posedge i_clk);
      cyc++;
    end
  end

  // Event counters, sampled just after the edge once outputs have settled.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (o_mul_start) start_total++;
      if (o_rsp_valid != '0) rsp_total++;
    end
  end

  // Requesters release their request on the cycle after their grant.
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_gnt != '0) i_req = i_req & ~o_gnt;
    end
  end

  // Signed product from plain integer arithmetic.
  function automatic logic [2*N-1:0] signedProd(input logic [N-1:0] a, input logic [N-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[2*N-1:0];
  endfunction

  // Behavioural multiplier: finishes mul_lat cycles after the start pulse,
  // or never when mul_hang is set. Between finishes the result bus carries
  // noise so a capture without the strobe is visible.
  initial begin
    i_mul_finish = 1'b0;
    i_mul_result = '0;
    forever begin
      @(negedge i_clk);
      i_mul_finish = 1'b0;
      i_mul_result = (2*N)'($urandom);
      if (!i_rst_n) begin
        mul_cnt = 0;
      end else begin
        if (mul_cnt > 0) begin
          mul_cnt--;
          if (mul_cnt == 0) begin
            i_mul_finish = 1'b1;
            i_mul_result = mul_prod;
          end
        end
        if (o_mul_start) begin
          mul_cnt  = mul_hang ? 0 : mul_lat;
          mul_prod = signedProd(o_mul_multiplier, o_mul_multiplicand);
        end
      end
    end
  end

  // Safety net in case every bounded wait is somehow bypassed.
  initial begin
    #600000;
    $display("[TB] FAIL global_time_limit: simulation still running, required finished");
    $fatal(1, "[TB] global time limit reached");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int k, input logic [N-1:0] a, input logic [N-1:0] b);
    i_a[k*N +: N] = a;
    i_b[k*N +: N] = b;
    i_req[k]      = 1'b1;
  endtask

  function automatic int oneHotIndex(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i] && r < 0) r = i;
    end
    return r;
  endfunction

  task automatic waitGrant(input int budget, output int gid, output int gcyc);
    bit done;
    done = 1'b0;
    gid  = -1;
    gcyc = -1;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge i_clk);
      if (o_gnt != '0) begin
        done = 1'b1;
        gid  = oneHotIndex(o_gnt);
        gcyc = cyc;
        checkOutput("gnt_onehot", 32'($onehot(o_gnt)), 32'd1);
        checkOutput("start_with_gnt", 32'(o_mul_start), 32'd1);
      end
    end
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL grant_wait: no grant within %0d cycles, required a grant", budget);
    end
  endtask

  task automatic waitResponse(input int budget, output int rid, output logic [2*N-1:0] rdata,
                              output logic rerr, output int rcyc);
    bit done;
    done  = 1'b0;
    rid   = -1;
    rdata = '0;
    rerr  = 1'b0;
    rcyc  = -1;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge i_clk);
      if (o_rsp_valid != '0) begin
        done  = 1'b1;
        rid   = oneHotIndex(o_rsp_valid);
        rdata = o_rsp_data;
        rerr  = o_rsp_err;
        rcyc  = cyc;
        checkOutput("rsp_onehot", 32'($onehot(o_rsp_valid)), 32'd1);
      end
    end
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL rsp_wait: no response within %0d cycles, required a response", budget);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"}, 32'(o_gnt), 32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_data"}, 32'(o_rsp_data), 32'd0);
    checkOutput({tag, "_rsp_err"}, 32'(o_rsp_err), 32'd0);
    checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
    checkOutput({tag, "_start"}, 32'(o_mul_start), 32'd0);
    checkOutput({tag, "_mul_a"}, 32'(o_mul_multiplier), 32'd0);
    checkOutput({tag, "_mul_b"}, 32'(o_mul_multiplicand), 32'd0);
  endtask

  task automatic doReset();
    @(negedge i_clk);
    i_rst_n  = 1'b0;
    i_req    = '0;
    mul_hang = 1'b0;
    mul_lat  = LAT;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // Main test sequence.
  initial begin
    int             gid, gcyc, rid, rcyc, prev_gcyc, prev_rcyc, snap, exp_id;
    logic [2*N-1:0] rdata;
    logic           rerr;
    logic [N-1:0]   a4[NREQ];
    logic [N-1:0]   b4[NREQ];
    bit             pend[NREQ];
    logic [N-1:0]   pa[NREQ];
    logic [N-1:0]   pb[NREQ];
    bit             hang, any;
    int             ptr_ref;

    vecs[0] = '{0, 8'h03, 8'h05, 16'h000F};
    vecs[1] = '{2, 8'hFD, 8'h05, 16'hFFF1};
    vecs[2] = '{1, 8'h7F, 8'h80, 16'hC080};
    vecs[3] = '{3, 8'h80, 8'h80, 16'h4000};
    vecs[4] = '{1, 8'hFF, 8'hFF, 16'h0001};
    vecs[5] = '{3, 8'h00, 8'h9C, 16'h0000};

    i_rst_n = 1'b0;
    i_req   = '0;
    i_a     = '0;
    i_b     = '0;
    repeat (3) @(negedge i_clk);
    checkAllZero("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Single-requester vectors: grant, operands, product, latency, one start.
    for (int v = 0; v < 6; v++) begin
      snap = start_total;
      applyStimulus(vecs[v].id, vecs[v].a, vecs[v].b);
      waitGrant(20, gid, gcyc);
      checkOutput("vec_gnt_id", 32'(gid), 32'(vecs[v].id));
      checkOutput("vec_mul_a", 32'(o_mul_multiplier), 32'(vecs[v].a));
      checkOutput("vec_mul_b", 32'(o_mul_multiplicand), 32'(vecs[v].b));
      waitResponse(TIMEOUT + 8, rid, rdata, rerr, rcyc);
      checkOutput("vec_rsp_id", 32'(rid), 32'(vecs[v].id));
      checkOutput("vec_rsp_data", 32'(rdata), 32'(vecs[v].prod));
      checkOutput("vec_rsp_err", 32'(rerr), 32'd0);
      checkOutput("vec_latency", 32'(rcyc - gcyc), 32'(LAT + 1));
      checkOutput("vec_one_start", 32'(start_total - snap), 32'd1);
      @(negedge i_clk);
      checkOutput("vec_rsp_one_cycle", 32'(o_rsp_valid), 32'd0);
      checkOutput("vec_data_idle", 32'(o_rsp_data), 32'd0);
      checkOutput("vec_idle_busy", 32'(o_busy), 32'd0);
    end

    // All four requests present as reset releases: served 0,1,2,3 back to back.
    a4 = '{8'h11, 8'hF0, 8'h7F, 8'h81};
    b4 = '{8'h02, 8'h10, 8'hFF, 8'h81};
    @(negedge i_clk);
    i_rst_n = 1'b0;
    for (int k = 0; k < NREQ; k++) applyStimulus(k, a4[k], b4[k]);
    repeat (2) @(negedge i_clk);
    i_rst_n   = 1'b1;
    prev_gcyc = 0;
    prev_rcyc = 0;
    for (int k = 0; k < NREQ; k++) begin
      waitGrant(30, gid, gcyc);
      checkOutput("all4_gnt_order", 32'(gid), 32'(k));
      if (k > 0) begin
        checkOutput("all4_no_overlap", 32'(gcyc > prev_rcyc), 32'd1);
        checkOutput("all4_spacing", 32'(gcyc - prev_gcyc), 32'(LAT + 3));
      end
      waitResponse(TIMEOUT + 8, rid, rdata, rerr, rcyc);
      checkOutput("all4_rsp_id", 32'(rid), 32'(k));
      checkOutput("all4_rsp_data", 32'(rdata), 32'(signedProd(a4[k], b4[k])));
      prev_gcyc = gcyc;
      prev_rcyc = rcyc;
    end

    // Watchdog: a multiplier that never finishes, then a normal job.
    @(negedge i_clk);
    mul_hang = 1'b1;
    applyStimulus(1, 8'h05, 8'h06);
    waitGrant(20, gid, gcyc);
    waitResponse(TIMEOUT + 8, rid, rdata, rerr, rcyc);
    checkOutput("tmo_rsp_id", 32'(rid), 32'd1);
    checkOutput("tmo_err", 32'(rerr), 32'd1);
    checkOutput("tmo_data", 32'(rdata), 32'd0);
    checkOutput("tmo_latency", 32'(rcyc - gcyc), 32'(TIMEOUT + 1));
    mul_hang = 1'b0;
    applyStimulus(1, 8'h02, 8'hFE);
    waitGrant(20, gid, gcyc);
    waitResponse(TIMEOUT + 8, rid, rdata, rerr, rcyc);
    checkOutput("post_tmo_data", 32'(rdata), 32'h0000FFFC);
    checkOutput("post_tmo_err", 32'(rerr), 32'd0);

    // Finish on the very last watchdog cycle still counts as success.
    mul_lat = TIMEOUT;
    applyStimulus(2, 8'h0C, 8'hF6);
    waitGrant(20, gid, gcyc);
    waitResponse(TIMEOUT + 8, rid, rdata, rerr, rcyc);
    checkOutput("edge_finish_err", 32'(rerr), 32'd0);
    checkOutput("edge_finish_data", 32'(rdata), 32'h0000FF88);
    checkOutput("edge_finish_latency", 32'(rcyc - gcyc), 32'(TIMEOUT + 1));

    // Finish one cycle too late: timeout, and the stray finish is ignored.
    mul_lat = TIMEOUT + 1;
    applyStimulus(3, 8'h09, 8'h09);
    waitGrant(20, gid, gcyc);
    waitResponse(TIMEOUT + 8, rid, rdata, rerr, rcyc);
    checkOutput("late_finish_err", 32'(rerr), 32'd1);
    checkOutput("late_finish_data", 32'(rdata), 32'd0);
    snap = rsp_total;
    repeat (5) @(negedge i_clk);
    checkOutput("late_finish_ignored", 32'(rsp_total), 32'(snap));
    checkOutput("late_finish_idle", 32'(o_busy), 32'd0);
    mul_lat = LAT;

    // Reset during WAIT: outputs clear, no response, pointer back to 0.
    applyStimulus(2, 8'h03, 8'h03);
    waitGrant(20, gid, gcyc);
    waitResponse(TIMEOUT + 8, rid, rdata, rerr, rcyc);
    applyStimulus(3, 8'h04, 8'h04);
    waitGrant(20, gid, gcyc);
    checkOutput("abort_gnt_id", 32'(gid), 32'd3);
    repeat (3) @(negedge i_clk);
    snap    = rsp_total;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    checkAllZero("abort");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (40) @(negedge i_clk);
    checkOutput("abort_no_rsp", 32'(rsp_total), 32'(snap));
    applyStimulus(3, 8'h05, 8'h05);
    applyStimulus(0, 8'h06, 8'h06);
    waitGrant(20, gid, gcyc);
    checkOutput("abort_ptr_zero", 32'(gid), 32'd0);
    waitResponse(TIMEOUT + 8, rid, rdata, rerr, rcyc);
    waitGrant(20, gid, gcyc);
    checkOutput("abort_next_gnt", 32'(gid), 32'd3);
    waitResponse(TIMEOUT + 8, rid, rdata, rerr, rcyc);
    checkOutput("abort_next_data", 32'(rdata), 32'h00000019);

    // Requesters 0 and 2 re-request right after every response.
    doReset();
    applyStimulus(0, 8'h07, 8'hF9);
    applyStimulus(2, 8'hC0, 8'h03);
    for (int t = 0; t < 8; t++) begin
      waitGrant(30, gid, gcyc);
      checkOutput("alt_gnt", 32'(gid), (t % 2 == 0) ? 32'd0 : 32'd2);
      waitResponse(TIMEOUT + 8, rid, rdata, rerr, rcyc);
      checkOutput("alt_data", 32'(rdata), (rid == 0) ? 32'h0000FFCF : 32'h0000FF40);
      if (t < 6 && rid >= 0) i_req[rid] = 1'b1;
    end

    // Randomized traffic against a round-robin reference.
    doReset();
    ptr_ref = 0;
    for (int k = 0; k < NREQ; k++) pend[k] = 1'b0;
    for (int t = 0; t < 40; t++) begin
      any = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          pend[k] = 1'b1;
          pa[k]   = N'($urandom);
          pb[k]   = N'($urandom);
          applyStimulus(k, pa[k], pb[k]);
        end
        if (pend[k]) any = 1'b1;
      end
      if (!any) begin
        exp_id       = $urandom_range(0, NREQ - 1);
        pend[exp_id] = 1'b1;
        pa[exp_id]   = N'($urandom);
        pb[exp_id]   = N'($urandom);
        applyStimulus(exp_id, pa[exp_id], pb[exp_id]);
      end
      hang     = ($urandom_range(0, 7) == 0);
      mul_hang = hang;
      mul_lat  = $urandom_range(1, 20);
      exp_id   = -1;
      for (int i = 0; i < NREQ; i++) begin
        if (exp_id < 0 && pend[(ptr_ref + i) % NREQ]) exp_id = (ptr_ref + i) % NREQ;
      end
      waitGrant(10, gid, gcyc);
      checkOutput("rnd_gnt", 32'(gid), 32'(exp_id));
      pend[exp_id] = 1'b0;
      waitResponse(TIMEOUT + 8, rid, rdata, rerr, rcyc);
      checkOutput("rnd_rsp_id", 32'(rid), 32'(exp_id));
      checkOutput("rnd_data", 32'(rdata), hang ? 32'd0 : 32'(signedProd(pa[exp_id], pb[exp_id])));
      checkOutput("rnd_err", 32'(rerr), 32'(hang));
      ptr_ref = (exp_id + 1) % NREQ;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
